// File: rtl/clk_reset_pkg.sv
// Shared definitions for the DCM reset sequencer: state encodings and
// small elaboration-time helpers used to size the internal counters.
package clk_reset_pkg;

   typedef enum logic [2:0] {
      DCM_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      SETTLE    = 3'd2,
      CALIB     = 3'd3,
      RUN       = 3'd4,
      FAIL      = 3'd5
   } state_t;

   localparam int LOSS_CNT_W = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Bits needed to count 0..n-1, never less than one.
   function automatic int width_for(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Capture the async level, then re-register it to let metastability settle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/clk_reset_seq.sv
// Reset sequencer behind the DCM: pulses the DCM reset, waits for a stable
// lock with timeout and bounded retries, then releases the DDR controller
// reset followed by the system reset. Lock loss in RUN re-sequences.
module clk_reset_seq
   import clk_reset_pkg::*;
#(
   parameter int DCM_RST_CYCLES = 4,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int STABLE_CYCLES  = 1024,
   parameter int MAX_RETRY      = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dcm_locked,
   input  logic                  ddr_calib_done,
   output logic                  dcm_rst,
   output logic                  ddr_rst,
   output logic                  sys_rst,
   output logic                  ready,
   output logic                  fail,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

   localparam int CNT_W   = width_for(max3(DCM_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
   localparam int RETRY_W = width_for(MAX_RETRY + 1);

   // Terminal counts: the state advances on the edge where the counter holds N-1.
   localparam logic [CNT_W-1:0]   DCM_RST_LAST = CNT_W'(DCM_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);
   localparam logic [LOSS_CNT_W-1:0] LOSS_SAT  = '1;

   logic                  w_lk;
   logic                  w_cal;
   logic                  w_retry_evt;
   state_t                w_state_next;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [RETRY_W-1:0]    r_retry;
   logic                  r_dcm_rst;
   logic                  r_ddr_rst;
   logic                  r_sys_rst;
   logic                  r_ready;
   logic                  r_fail;
   logic [LOSS_CNT_W-1:0] r_loss_cnt;

   sync_2ff u_sync_lock (
      .clk (clk),
      .rst (rst),
      .i_d (dcm_locked),
      .o_q (w_lk)
   );

   sync_2ff u_sync_cal (
      .clk (clk),
      .rst (rst),
      .i_d (ddr_calib_done),
      .o_q (w_cal)
   );

   // Next-state decision; a lock drop always outranks calibration done,
   // and a lock seen on the timeout cycle outranks the timeout.
   always_comb begin
      w_retry_evt  = 1'b0;
      w_state_next = r_state;
      case (r_state)
         DCM_RST: begin
            if (r_cnt == DCM_RST_LAST) w_state_next = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (w_lk)                    w_state_next = SETTLE;
            else if (r_cnt == LOCK_LAST) w_retry_evt  = 1'b1;
         end
         SETTLE: begin
            if (!w_lk)                     w_retry_evt  = 1'b1;
            else if (r_cnt == STABLE_LAST) w_state_next = CALIB;
         end
         CALIB: begin
            if (!w_lk)      w_retry_evt  = 1'b1;
            else if (w_cal) w_state_next = RUN;
         end
         RUN: begin
            if (!w_lk) w_state_next = DCM_RST;
         end
         FAIL: begin
            w_state_next = FAIL;
         end
         default: begin
            w_state_next = DCM_RST;
         end
      endcase
      if (w_retry_evt) w_state_next = (r_retry == RETRY_MAX) ? FAIL : DCM_RST;
   end

   // State, counters and outputs; outputs are decoded from the next state so
   // they change on the same edge as the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= DCM_RST;
         r_cnt      <= '0;
         r_retry    <= '0;
         r_dcm_rst  <= 1'b1;
         r_ddr_rst  <= 1'b1;
         r_sys_rst  <= 1'b1;
         r_ready    <= 1'b0;
         r_fail     <= 1'b0;
         r_loss_cnt <= '0;
      end else begin
         r_state <= w_state_next;

         if (w_state_next != r_state)
            r_cnt <= '0;
         else if (r_state inside {DCM_RST, WAIT_LOCK, SETTLE})
            r_cnt <= r_cnt + 1'b1;

         if (w_retry_evt && (r_retry != RETRY_MAX))
            r_retry <= r_retry + 1'b1;
         else if (w_state_next == RUN)
            r_retry <= '0;

         if ((r_state == RUN) && !w_lk && (r_loss_cnt != LOSS_SAT))
            r_loss_cnt <= r_loss_cnt + 1'b1;

         r_dcm_rst <= (w_state_next == DCM_RST);
         r_ddr_rst <= !((w_state_next == CALIB) || (w_state_next == RUN));
         r_sys_rst <= (w_state_next != RUN);
         r_ready   <= (w_state_next == RUN);
         r_fail    <= (w_state_next == FAIL);
      end
   end

   assign dcm_rst       = r_dcm_rst;
   assign ddr_rst       = r_ddr_rst;
   assign sys_rst       = r_sys_rst;
   assign ready         = r_ready;
   assign fail          = r_fail;
   assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_clk_reset_seq.sv
// Bench for clk_reset_seq: directed bring-up / timeout / glitch / lock-loss /
// saturation scenarios plus randomized input segments, all checked each cycle
// against a phase/age reference model.
`timescale 1ns/1ps
module tb_clk_reset_seq;

   localparam int P_DCM   = 4;
   localparam int P_TO    = 100;
   localparam int P_STAB  = 16;
   localparam int P_RETRY = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dcm_locked = 1'b0;
   logic       ddr_calib_done = 1'b0;
   logic       dcm_rst;
   logic       ddr_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [7:0] lock_loss_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit armed   = 1'b0;

   always #15 clk = ~clk;

   clk_reset_seq #(
      .DCM_RST_CYCLES (P_DCM),
      .LOCK_TIMEOUT   (P_TO),
      .STABLE_CYCLES  (P_STAB),
      .MAX_RETRY      (P_RETRY)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .dcm_locked     (dcm_locked),
      .ddr_calib_done (ddr_calib_done),
      .dcm_rst        (dcm_rst),
      .ddr_rst        (ddr_rst),
      .sys_rst        (sys_rst),
      .ready          (ready),
      .fail           (fail),
      .lock_loss_cnt  (lock_loss_cnt)
   );

   // cyc at a falling edge = index of the cycle whose outputs are visible.
   initial forever begin
      @(posedge clk);
      cyc <= rst ? 0 : cyc + 1;
   end

   // ---------------- reference model ----------------
   typedef enum int {PH_PULSE, PH_WAIT, PH_SETTLE, PH_CALIB, PH_RUN, PH_DEAD} phase_t;
   typedef struct {
      phase_t ph;
      int     age;
      int     retries;
      int     losses;
      bit     lk_a, lk_b, cal_a, cal_b;
   } model_t;

   model_t m;

   function automatic model_t model_next(model_t cur, logic r, logic lk_in, logic cal_in);
      model_t n;
      bit     lk, cal, retry_hit;
      phase_t nxt;
      n = cur;
      if (r) begin
         n.ph = PH_PULSE; n.age = 0; n.retries = 0; n.losses = 0;
         n.lk_a = 0; n.lk_b = 0; n.cal_a = 0; n.cal_b = 0;
         return n;
      end
      lk  = cur.lk_b;
      cal = cur.cal_b;
      n.lk_a  = lk_in;  n.lk_b  = cur.lk_a;
      n.cal_a = cal_in; n.cal_b = cur.cal_a;
      nxt = cur.ph;
      retry_hit = 0;
      case (cur.ph)
         PH_PULSE:  if (cur.age + 1 == P_DCM) nxt = PH_WAIT;
         PH_WAIT:   if (lk) nxt = PH_SETTLE; else if (cur.age + 1 == P_TO) retry_hit = 1;
         PH_SETTLE: if (!lk) retry_hit = 1; else if (cur.age + 1 == P_STAB) nxt = PH_CALIB;
         PH_CALIB:  if (!lk) retry_hit = 1; else if (cal) nxt = PH_RUN;
         PH_RUN:    if (!lk) begin
                       n.losses = (cur.losses >= 255) ? 255 : cur.losses + 1;
                       nxt = PH_PULSE;
                    end
         default:   ;
      endcase
      if (retry_hit) begin
         if (cur.retries >= P_RETRY) nxt = PH_DEAD;
         else begin
            n.retries = cur.retries + 1;
            nxt = PH_PULSE;
         end
      end
      if (nxt == PH_RUN) n.retries = 0;
      n.age = (nxt == cur.ph) ? cur.age + 1 : 0;
      n.ph  = nxt;
      return n;
   endfunction

   // {dcm_rst, ddr_rst, sys_rst, ready, fail, lock_loss_cnt}
   function automatic logic [12:0] expect_vec(model_t mm);
      logic [7:0] l;
      l = 8'(mm.losses);
      return {mm.ph == PH_PULSE, !(mm.ph == PH_CALIB || mm.ph == PH_RUN),
              mm.ph != PH_RUN, mm.ph == PH_RUN, mm.ph == PH_DEAD, l};
   endfunction

   initial forever begin
      @(posedge clk);
      m <= model_next(m, rst, dcm_locked, ddr_calib_done);
   end

   // Every-cycle comparison of all outputs against the model.
   initial forever begin
      @(negedge clk);
      if (armed) begin
         n_tests++;
         if ({dcm_rst, ddr_rst, sys_rst, ready, fail, lock_loss_cnt} !== expect_vec(m)) begin
            n_fail++;
            $display("FAIL model_cmp cyc=%0d got=%b want=%b", cyc,
                     {dcm_rst, ddr_rst, sys_rst, ready, fail, lock_loss_cnt}, expect_vec(m));
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check_bit(input string name, input logic got, input logic want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
      end
   endtask

   task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
      end
   endtask

   task automatic to_cycle(input int k);
      int guard = 0;
      while (cyc != k && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != k) begin
         n_tests++;
         n_fail++;
         $display("FAIL to_cycle got=%0d want=%0d", cyc, k);
      end
   endtask

   task automatic wait_ready(input logic want, input int budget, input string name);
      int n = 0;
      while (ready !== want && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_bit(name, ready, want);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      dcm_locked = 1'b0;
      ddr_calib_done = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      // Clean bring-up
      do_reset();
      armed = 1'b1;
      check_bit("rst_dcm_rst", dcm_rst, 1'b1);
      check_bit("rst_ddr_rst", ddr_rst, 1'b1);
      check_bit("rst_sys_rst", sys_rst, 1'b1);
      check_bit("rst_ready",   ready,   1'b0);
      check_bit("rst_fail",    fail,    1'b0);
      check_byte("rst_loss",   lock_loss_cnt, 8'd0);
      to_cycle(3);  check_bit("dcm_rst_c3", dcm_rst, 1'b1);
      to_cycle(4);  check_bit("dcm_rst_c4", dcm_rst, 1'b0);
      to_cycle(20); dcm_locked = 1'b1;
      to_cycle(38); check_bit("ddr_rst_c38", ddr_rst, 1'b1);
      to_cycle(39); check_bit("ddr_rst_c39", ddr_rst, 1'b0);
      to_cycle(60); ddr_calib_done = 1'b1;
      to_cycle(62); check_bit("sys_rst_c62", sys_rst, 1'b1);
                    check_bit("ready_c62",   ready,   1'b0);
      to_cycle(63); check_bit("sys_rst_c63", sys_rst, 1'b0);
                    check_bit("ready_c63",   ready,   1'b1);

      // Lock loss in RUN at t=80, re-lock at 90
      to_cycle(80); dcm_locked = 1'b0;
      to_cycle(82); check_bit("loss_ready_t2", ready, 1'b1);
      to_cycle(83); check_bit("loss_sys_t3", sys_rst, 1'b1);
                    check_bit("loss_ddr_t3", ddr_rst, 1'b1);
                    check_bit("loss_dcm_t3", dcm_rst, 1'b1);
                    check_bit("loss_ready_t3", ready, 1'b0);
                    check_byte("loss_cnt_t3", lock_loss_cnt, 8'd1);
      to_cycle(90);  dcm_locked = 1'b1;
      to_cycle(109); check_bit("relock_ready_109", ready, 1'b0);
      to_cycle(110); check_bit("relock_ready_110", ready, 1'b1);

      // Lock timeout with lock held low
      do_reset();
      to_cycle(103); check_bit("to_dcm_103", dcm_rst, 1'b0);
      to_cycle(104); check_bit("to_dcm_104", dcm_rst, 1'b1);
      to_cycle(207); check_bit("to_dcm_207", dcm_rst, 1'b0);
      to_cycle(208); check_bit("to_dcm_208", dcm_rst, 1'b1);
      to_cycle(311); check_bit("to_fail_311", fail, 1'b0);
      to_cycle(312); check_bit("to_fail_312", fail, 1'b1);
                     check_bit("to_dcm_312", dcm_rst, 1'b0);
      to_cycle(330); check_bit("to_fail_330", fail, 1'b1);
                     check_bit("to_sys_330", sys_rst, 1'b1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); check_bit("fail_cleared", fail, 1'b0);
                      check_bit("fail_rst_dcm", dcm_rst, 1'b1);

      // Glitchy lock: 10 cycles of lk in SETTLE, then a stable lock
      do_reset();
      to_cycle(20); dcm_locked = 1'b1;
      to_cycle(31); dcm_locked = 1'b0;
      to_cycle(33); check_bit("glitch_dcm_33", dcm_rst, 1'b0);
      to_cycle(34); check_bit("glitch_dcm_34", dcm_rst, 1'b1);
                    check_bit("glitch_ddr_34", ddr_rst, 1'b1);
      to_cycle(40); dcm_locked = 1'b1; ddr_calib_done = 1'b1;
      to_cycle(59); check_bit("glitch_ready_59", ready, 1'b0);
      to_cycle(60); check_bit("glitch_ready_60", ready, 1'b1);
      // RUN cleared the retry used by the glitch: a full three timeouts to fail.
      to_cycle(70);  dcm_locked = 1'b0;
      to_cycle(384); check_bit("retry_clr_fail_384", fail, 1'b0);
      to_cycle(385); check_bit("retry_clr_fail_385", fail, 1'b1);

      // Randomized segments
      do_reset();
      for (int s = 0; s < 120; s++) begin
         int len;
         if ($urandom_range(0, 99) < 4) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         dcm_locked     = ($urandom_range(0, 3) != 0);
         ddr_calib_done = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 220))
                                           : int'($urandom_range(1, 40));
         repeat (len) @(negedge clk);
      end

      // Lock-loss counter saturation, then reset from RUN
      do_reset();
      ddr_calib_done = 1'b1;
      for (int i = 0; i < 257; i++) begin
         dcm_locked = 1'b1;
         wait_ready(1'b1, 200, "sat_up");
         dcm_locked = 1'b0;
         wait_ready(1'b0, 10, "sat_down");
      end
      check_byte("sat_cnt", lock_loss_cnt, 8'd255);
      dcm_locked = 1'b1;
      wait_ready(1'b1, 200, "sat_final_up");
      rst = 1'b1;
      @(negedge clk);
      check_bit("rrun_dcm_rst", dcm_rst, 1'b1);
      check_bit("rrun_ddr_rst", ddr_rst, 1'b1);
      check_bit("rrun_sys_rst", sys_rst, 1'b1);
      check_bit("rrun_ready",   ready,   1'b0);
      check_bit("rrun_fail",    fail,    1'b0);
      check_byte("rrun_loss",   lock_loss_cnt, 8'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
